mem_port_arbiter: RTL

Sequencer and arbiter for the CPU's single-ported unified memory, shared between instruction fetch and the data accesses (LW, SW, CALL push, RET pop) requested by the control logic through MemRead/MemWrite. It grants one requester at a time and drives a req/ready handshake to memory. It returns read data with a one-cycle valid pulse, stalls the pipeline while an access is outstanding, and freezes on HALT. It sits between the fetch/memory pipeline stages and the memory macro.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port, halt/stall and memory-side
// handshake signals around the unified memory arbiter.
//
// Handshake: a requester raises its request (if_req, or d_rd/d_wr) with
// stable address/data and holds it until the matching one-cycle valid
// pulse. Toward memory, mem_en acts as "valid": once high it stays high
// with stable mem_addr/mem_we/mem_wdata until mem_rdy ("ready") is seen
// high on a rising edge. That edge completes the transfer, and mem_rdata
// is sampled on it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_data;
  logic              if_valid;
  logic              d_rd;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              halt;
  logic              stall;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              err;
  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata, mem_rdy,
    output if_data, if_valid, d_rdata, d_valid, stall, mem_en, mem_we,
           mem_addr, mem_wdata, err, busy
  );

  // Pipeline plus memory side (driven together by the environment)
  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, halt, mem_rdata, mem_rdy,
    input  if_data, if_valid, d_rdata, d_valid, stall, mem_en, mem_we,
           mem_addr, mem_wdata, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single-ported unified memory. It serves
// instruction fetch and data accesses one at a time. Data normally wins,
// but fetch wins a tie right after a data grant so that it cannot starve.
// A watchdog parks the block in a sticky error state if memory never answers.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mem_port_arbiter_if.slave     bus,
  output logic [2:0]            o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DATA   = 3'd2,
    S_HALTED = 3'd3,
    S_ERROR  = 3'd4
  } state_e;

  // The counter holds the number of cycles already spent waiting. The
  // access times out on the wait cycle that would make it reach TIMEOUT.
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_last_data;   // 1: most recent grant went to data
  logic [7:0]          r_cnt;
  logic                r_is_rd;       // current DATA access returns read data
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_if_data;
  logic                r_if_valid;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_d_valid;
  logic                r_err;

  logic                w_d_elig;
  logic                w_f_elig;
  logic                w_pick_d;
  logic                w_pick_f;
  logic                w_grant_d;
  logic                w_grant_f;
  logic                w_done;
  logic                w_timeout;
  logic                w_busy;

  // A requester whose valid pulse is high this cycle is still holding a
  // request that has already been served, so it is not eligible.
  assign w_d_elig = (bus.d_rd | bus.d_wr) & ~r_d_valid;
  assign w_f_elig = bus.if_req & ~r_if_valid;
  assign w_pick_d = w_d_elig & ~(w_f_elig & r_last_data);
  assign w_pick_f = w_f_elig & ~w_pick_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; HALTED and ERROR are left only through reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.halt)      w_state_nxt = S_HALTED;
        else if (w_pick_d) w_state_nxt = S_DATA;
        else if (w_pick_f) w_state_nxt = S_FETCH;
      end
      S_FETCH, S_DATA: begin
        if (bus.mem_rdy)                 w_state_nxt = S_IDLE;
        else if (r_cnt == LP_CNT_LAST)   w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  // Output/strobe decode: grants, completion and timeout events per state
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_f = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!bus.halt) begin
          w_grant_d = w_pick_d;
          w_grant_f = w_pick_f;
        end
      end
      S_FETCH, S_DATA: begin
        w_busy    = 1'b1;
        w_done    = bus.mem_rdy;
        w_timeout = ~bus.mem_rdy & (r_cnt == LP_CNT_LAST);
      end
      default: ;
    endcase
  end

  // Datapath: latch the granted access, hold it on the memory bus, and
  // capture the returned data with a one-cycle valid pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= 1'b0;
      r_cnt       <= 8'd0;
      r_is_rd     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_data   <= '0;
      r_if_valid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_valid   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_if_valid <= w_done & (r_state == S_FETCH);
      r_d_valid  <= w_done & (r_state == S_DATA);
      if (w_grant_d) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= bus.d_wr;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_is_rd     <= bus.d_rd & ~bus.d_wr;   // read+write together acts as a write
        r_cnt       <= 8'd0;
        r_last_data <= 1'b1;
      end else if (w_grant_f) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= bus.if_addr;
        r_is_rd     <= 1'b0;
        r_cnt       <= 8'd0;
        r_last_data <= 1'b0;
      end else if (w_done) begin
        r_mem_en <= 1'b0;
        if (r_state == S_FETCH)  r_if_data <= bus.mem_rdata;
        else if (r_is_rd)        r_d_rdata <= bus.mem_rdata;
      end else if (w_timeout) begin
        r_mem_en <= 1'b0;
        r_err    <= 1'b1;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_data   = r_if_data;
  assign bus.if_valid  = r_if_valid;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_valid   = r_d_valid;
  assign bus.err       = r_err;
  assign bus.busy      = w_busy;
  assign bus.stall     = ((bus.d_rd | bus.d_wr) & ~r_d_valid)
                       | (bus.if_req & ~r_if_valid)
                       | (r_state == S_HALTED)
                       | (r_state == S_ERROR);
  assign o_dbg_state   = r_state;

endmodule
